// File: rtl/pair_topk.sv
// pair_topk: keeps the K closest point pairs seen in a stream and drains them
// in ascending distance order.
//
// Entries E[0..K-1] hold {dist, point a, point b, valid}. E[0] is the smallest.
// Valid entries are always packed from index 0 and sorted by nondecreasing
// distance. A new pair goes in after every entry whose distance is <= its own,
// so pairs with equal distances stay in arrival order. When the array is full
// the largest entry falls off the end. A pair that would land at index K is
// discarded.
//
// FSM: COLLECT (busy=0) accepts pairs. An in_done pulse moves to DRAIN when at
// least one entry is held. DRAIN (busy=1) streams E[0] out and shifts the
// array down on every handshake, then returns to COLLECT.
// The busy output is the FSM state.
//
// Ports:
//   clk, rst                       clock; synchronous active-high reset
//   in_dist/in_pointa/in_pointb    incoming pair, qualified by in_vld
//   in_done                        1-cycle pulse: input stream complete
//   out_dist/out_pointa/out_pointb head of list (register driven)
//   out_vld/out_rdy                output handshake
//   out_last                       head is the final entry (qualified by out_vld)
//   count                          entries currently held
//   busy                           1 while draining
//   drop_err                       sticky: a pair arrived during drain
//
// Handshake: out_* and out_last are only meaningful while out_vld=1. A
// transfer happens on a rising clk edge where out_vld & out_rdy. While
// out_vld=1 and out_rdy=0, out_* hold stable. out_vld never drops without a
// transfer, except on rst. The input side has no backpressure.
module pair_topk #(
  parameter int NUM_POINTS = 1000,
  parameter int DIM_W      = 17,
  parameter int K          = 1000,
  parameter int DIST_W     = (DIM_W + 1) * 2 + 2,
  parameter int IDX_W      = $clog2(NUM_POINTS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DIST_W-1:0]        in_dist,
  input  logic [IDX_W-1:0]         in_pointa,
  input  logic [IDX_W-1:0]         in_pointb,
  input  logic                     in_vld,
  input  logic                     in_done,
  output logic [DIST_W-1:0]        out_dist,
  output logic [IDX_W-1:0]         out_pointa,
  output logic [IDX_W-1:0]         out_pointb,
  output logic                     out_vld,
  input  logic                     out_rdy,
  output logic                     out_last,
  output logic [$clog2(K+1)-1:0]   count,
  output logic                     busy,
  output logic                     drop_err
);

  localparam int CNT_W = $clog2(K + 1);
  localparam logic [CNT_W-1:0] K_CNT   = CNT_W'(K);
  localparam logic [CNT_W-1:0] ONE_CNT = CNT_W'(1);

  localparam logic [0:0] COLLECT = 1'b0;
  localparam logic [0:0] DRAIN   = 1'b1;

  logic [0:0]        state, state_nxt;
  logic [DIST_W-1:0] e_dist [K];
  logic [IDX_W-1:0]  e_a    [K];
  logic [IDX_W-1:0]  e_b    [K];
  logic [K-1:0]      e_v;

  logic [DIST_W-1:0] n_dist [K];
  logic [IDX_W-1:0]  n_a    [K];
  logic [IDX_W-1:0]  n_b    [K];
  logic [K-1:0]      n_v;
  logic [CNT_W-1:0]  count_nxt;
  logic              drop_err_nxt;

  // le[i]: entry i stays where it is on an insert. Because the array is sorted
  // and packed, le is a run of ones from bit 0, and the insert position is the
  // first zero.
  logic [K-1:0] le;
  logic         ins;
  logic         out_fire;

  assign busy       = (state == DRAIN);
  assign out_vld    = busy && (count != '0);
  assign out_last   = out_vld && (count == ONE_CNT);
  assign out_dist   = e_dist[0];
  assign out_pointa = e_a[0];
  assign out_pointb = e_b[0];
  assign out_fire   = out_vld && out_rdy;

  always_comb begin
    for (int i = 0; i < K; i++) begin
      le[i] = e_v[i] && (e_dist[i] <= in_dist);
    end
    // When le[K-1] is set the array is full and the pair would land at index K.
    ins = (state == COLLECT) && in_vld && !le[K-1];

    for (int i = 0; i < K; i++) begin
      n_dist[i] = e_dist[i];
      n_a[i]    = e_a[i];
      n_b[i]    = e_b[i];
    end
    n_v          = e_v;
    count_nxt    = count;
    state_nxt    = state;
    drop_err_nxt = drop_err | (busy && in_vld);

    if (state == COLLECT) begin
      if (ins) begin
        if (!le[0]) begin
          n_dist[0] = in_dist;
          n_a[0]    = in_pointa;
          n_b[0]    = in_pointb;
          n_v[0]    = 1'b1;
        end
        for (int i = 1; i < K; i++) begin
          if (!le[i]) begin
            if (le[i-1]) begin
              n_dist[i] = in_dist;
              n_a[i]    = in_pointa;
              n_b[i]    = in_pointb;
              n_v[i]    = 1'b1;
            end else begin
              n_dist[i] = e_dist[i-1];
              n_a[i]    = e_a[i-1];
              n_b[i]    = e_b[i-1];
              n_v[i]    = e_v[i-1];
            end
          end
        end
        if (count != K_CNT) count_nxt = count + ONE_CNT;
      end
      // The same-cycle pair is already counted in count_nxt.
      if (in_done && (count_nxt != '0)) state_nxt = DRAIN;
    end else if (out_fire) begin
      for (int i = 0; i < K - 1; i++) begin
        n_dist[i] = e_dist[i+1];
        n_a[i]    = e_a[i+1];
        n_b[i]    = e_b[i+1];
        n_v[i]    = e_v[i+1];
      end
      n_dist[K-1] = '0;
      n_a[K-1]    = '0;
      n_b[K-1]    = '0;
      n_v[K-1]    = 1'b0;
      count_nxt   = count - ONE_CNT;
      if (count == ONE_CNT) state_nxt = COLLECT;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= COLLECT;
      count    <= '0;
      drop_err <= 1'b0;
      e_v      <= '0;
      for (int i = 0; i < K; i++) begin
        e_dist[i] <= '0;
        e_a[i]    <= '0;
        e_b[i]    <= '0;
      end
    end else begin
      state    <= state_nxt;
      count    <= count_nxt;
      drop_err <= drop_err_nxt;
      e_v      <= n_v;
      for (int i = 0; i < K; i++) begin
        e_dist[i] <= n_dist[i];
        e_a[i]    <= n_a[i];
        e_b[i]    <= n_b[i];
      end
    end
  end

endmodule
